// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the sequential arithmetic units.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_ITER = 16;
  localparam int CNT_W    = 5;

endpackage

// File: rtl/shift_add_mul16_if.sv
// Start/busy/done handshake plus operand and product buses of the multiplier.
interface shift_add_mul16_if;
  logic        start;
  logic [15:0] X;
  logic [15:0] Y;
  logic        busy;
  logic        done;
  logic [31:0] P;

  modport master (output start, X, Y, input busy, done, P);
  modport slave  (input start, X, Y, output busy, done, P);
endinterface

// File: rtl/CLA_16.sv
// 16-bit carry-lookahead adder: 4-bit lookahead groups, group carries from
// generate/propagate terms.
module CLA_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        c
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] cy;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  cb;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, group carries, then per-bit carries inside each group.
  always_comb begin
    gg = '0;
    gp = '0;
    cb = '0;
    cy = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
    end
    cb[0] = cin;
    for (int k = 0; k < 4; k++) begin
      cb[k+1] = gg[k] | (gp[k] & cb[k]);
    end
    for (int k = 0; k < 4; k++) begin
      cy[4*k] = cb[k];
      for (int j = 1; j < 4; j++) begin
        cy[4*k+j] = g[4*k+j-1] | (p[4*k+j-1] & cy[4*k+j-1]);
      end
    end
  end

  assign s = p ^ cy;
  assign c = cb[4];
endmodule

// File: rtl/shift_add_mul16.sv
// Sequential 16x16 unsigned shift-and-add multiplier built around one CLA_16.
module shift_add_mul16
  import mul_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  shift_add_mul16_if.slave bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      a_q, a_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      q_q, q_d;
  logic [31:0]      p_q, p_d;
  logic [15:0]      sum;
  logic             carry;

  CLA_16 u_cla (
    .a   (h_q),
    .b   (a_q),
    .cin (1'b0),
    .s   (sum),
    .c   (carry)
  );

  // Next-state, counter and datapath shift; P is captured on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    h_d     = h_q;
    q_d     = q_q;
    p_d     = p_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.X;
          h_d     = '0;
          q_d     = bus.Y;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The adder carry becomes the new MSB of H, so no bit of the product is lost.
        if (q_q[0]) {h_d, q_d} = {carry, sum, q_q[15:1]};
        else        {h_d, q_d} = {1'b0, h_q, q_q[15:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_ITER - 1)) begin
          state_d = DONE;
          p_d     = {h_d, q_d};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      h_q     <= '0;
      q_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      h_q     <= h_d;
      q_q     <= q_d;
      p_q     <= p_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.P    = p_q;
endmodule

// File: tb/tb_shift_add_mul16.sv
// Randomised and directed checks of shift_add_mul16 against X*Y.
module tb_shift_add_mul16;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [31:0] last_p;

  shift_add_mul16_if bus ();

  shift_add_mul16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one operation (start sampled at edge 0) and observes it until busy drops.
  // inj > 0 drives a competing start with X=Y=0xFFFF sampled at edge inj.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input int inj,
                        output int lat, output int dw, output int bc,
                        output logic [31:0] pr, output logic [31:0] pmid,
                        output logic [31:0] pend, output bit to);
    lat = -1; dw = 0; bc = 0; pr = '0; pmid = '0; pend = '0; to = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.X = x; bus.Y = y;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.X = 16'($urandom); bus.Y = 16'($urandom);
    if (bus.busy) bc++;
    if (bus.done) dw++;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == inj) begin
        bus.start = 1'b1; bus.X = 16'hFFFF; bus.Y = 16'hFFFF;
      end else begin
        bus.start = 1'b0; bus.X = 16'($urandom); bus.Y = 16'($urandom);
      end
      @(posedge clk); #1;
      if (bus.busy) bc++;
      if (bus.done) begin
        dw++;
        if (lat < 0) begin lat = n; pr = bus.P; end
      end
      if (n == 8) pmid = bus.P;
      if (!bus.busy) begin pend = bus.P; to = 1'b0; break; end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.X = '0; bus.Y = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.P !== 32'h0) begin bad++; $display("FAIL reset_P got=%h exp=0", bus.P); end
    @(negedge clk); rst_n = 1'b1;
    last_p = '0;
  endtask

  // Full protocol check of a single operation against the arithmetic product.
  task automatic test_op(input string nm, input logic [15:0] x, input logic [15:0] y);
    int lat, dw, bc; logic [31:0] pr, pmid, pend; bit to; logic [31:0] exp_p;
    exp_p = 32'(x) * 32'(y);
    run_op(x, y, 0, lat, dw, bc, pr, pmid, pend, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL %s_timeout busy never fell", nm); end
    total++; if (pr !== exp_p) begin bad++; $display("FAIL %s_P x=%h y=%h got=%h exp=%h", nm, x, y, pr, exp_p); end
    total++; if (lat !== 16) begin bad++; $display("FAIL %s_latency got=%0d exp=16 edges", nm, lat); end
    total++; if (dw !== 1) begin bad++; $display("FAIL %s_done_width got=%0d exp=1", nm, dw); end
    total++; if (bc !== 17) begin bad++; $display("FAIL %s_busy_cycles got=%0d exp=17", nm, bc); end
    total++; if (pmid !== last_p) begin bad++; $display("FAIL %s_P_hold_run got=%h exp=%h", nm, pmid, last_p); end
    total++; if (pend !== exp_p) begin bad++; $display("FAIL %s_P_hold_idle got=%h exp=%h", nm, pend, exp_p); end
    last_p = exp_p;
  endtask

  task automatic test_basic();
    test_op("basic_3x5", 16'd3, 16'd5);
  endtask

  task automatic test_max();
    test_op("max", 16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_zero();
    test_op("zero_y", 16'h1234, 16'h0000);
    test_op("zero_x", 16'h0000, 16'hABCD);
  endtask

  task automatic test_ignored_start();
    int lat, dw, bc; logic [31:0] pr, pmid, pend; bit to;
    run_op(16'd7, 16'd9, 5, lat, dw, bc, pr, pmid, pend, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL ign_timeout busy never fell"); end
    total++; if (pr !== 32'd63) begin bad++; $display("FAIL ign_P got=%h exp=%h", pr, 32'd63); end
    total++; if (lat !== 16) begin bad++; $display("FAIL ign_latency got=%0d exp=16", lat); end
    total++; if (dw !== 1) begin bad++; $display("FAIL ign_done_width got=%0d exp=1", dw); end
    total++; if (bc !== 17) begin bad++; $display("FAIL ign_busy_cycles got=%0d exp=17", bc); end
    total++; if (pend !== 32'd63) begin bad++; $display("FAIL ign_P_idle got=%h exp=%h", pend, 32'd63); end
    last_p = 32'd63;
    test_op("after_ign", 16'hFFFF, 16'hFFFF);
  endtask

  task automatic test_reset_mid();
    int dcount, bcount;
    @(negedge clk);
    bus.start = 1'b1; bus.X = 16'h00FF; bus.Y = 16'h00FF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 8) rst_n = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    total++; if (bus.P !== 32'h0) begin bad++; $display("FAIL midrst_P got=%h exp=0", bus.P); end
    @(negedge clk); rst_n = 1'b1;
    dcount = 0; bcount = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
      if (bus.busy) bcount++;
    end
    total++; if (dcount !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", dcount); end
    total++; if (bcount !== 0) begin bad++; $display("FAIL midrst_no_busy got=%0d exp=0", bcount); end
    last_p = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      test_op("rand", 16'($urandom), 16'($urandom));
    end
  endtask

  initial begin
    total = 0; bad = 0; last_p = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
